// File: rtl/seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// seq_detect_ctrl
//
// Programmable serial pattern-detection controller. Holds the detector
// configuration (pattern, length, overlap mode, observation window), sequences
// a detection run IDLE -> RUN -> DONE -> IDLE, shifts qualified input bits
// into a history register and counts Moore-style matches.
//
// Parameters:
//   PAT_W  maximum pattern length in bits (>= 2)
//   CNT_W  saturating match counter width
//   WIN_W  observation-window counter width
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   cfg_valid    config offer; accepted when cfg_valid & cfg_ready
//   cfg_ready    high only in IDLE
//   cfg_pattern  pattern; bit [len-1] is the first bit received
//   cfg_len      pattern length, legal 1..PAT_W (0 = unconfigured)
//   cfg_overlap  1 = overlapping matches allowed
//   cfg_window   valid bits per run, 0 = unlimited
//   start        begin a run (honoured in IDLE with a legal length)
//   stop         abort a run (honoured in RUN)
//   din          serial data bit
//   din_valid    din qualifier
//   busy         run in progress
//   match        registered one-cycle match flag
//   match_cnt    matches in the current / last run
//   done         one-cycle pulse after a run ends
//   win_expired  sticky: last run ended by its window rather than stop
//
// Optional feature (macro SEQ_DETECT_FIRST_POS_EN):
//   first_pos    1-based valid-bit index of the first match of the run
//   first_vld    first_pos holds a captured value
// -----------------------------------------------------------------------------
module seq_detect_ctrl #(
    parameter  int PAT_W = 8,
    parameter  int CNT_W = 8,
    parameter  int WIN_W = 16,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic             start,
    input  logic             stop,
    input  logic             din,
    input  logic             din_valid,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done,
`ifdef SEQ_DETECT_FIRST_POS_EN
    output logic [WIN_W-1:0] first_pos,
    output logic             first_vld,
`endif
    output logic             win_expired
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [WIN_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             match_q, match_d;
    logic             wexp_q, wexp_d;
`ifdef SEQ_DETECT_FIRST_POS_EN
    logic [WIN_W-1:0] fpos_q, fpos_d;
    logic             fvld_q, fvld_d;
`endif

    // Values the registers take if the current cycle carries a valid bit.
    logic [PAT_W-1:0] hist_shift;
    logic [LEN_W-1:0] fill_inc;
    logic [WIN_W-1:0] wcnt_inc;
    logic [PAT_W-1:0] pat_mask;
    logic             hit;
    logic             len_ok;

    always_comb begin
        hist_shift = {hist_q[PAT_W-2:0], din};
        fill_inc   = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
        wcnt_inc   = wcnt_q + WIN_W'(1);
        for (int i = 0; i < PAT_W; i++) begin
            pat_mask[i] = (i < int'(len_q));
        end
        // Compare only the low len bits; fill guards against matching on
        // history that predates the run or a non-overlap restart.
        hit    = (fill_inc >= len_q) && (((hist_shift ^ pat_q) & pat_mask) == '0);
        len_ok = (len_q != '0) && (len_q <= LEN_W'(PAT_W));
    end

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        win_d   = win_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        wcnt_d  = wcnt_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;
        wexp_d  = wexp_q;
`ifdef SEQ_DETECT_FIRST_POS_EN
        fpos_d  = fpos_q;
        fvld_d  = fvld_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                // A same-cycle config offer is still latched; start is judged
                // against the length already held.
                if (cfg_valid) begin
                    pat_d = cfg_pattern;
                    len_d = cfg_len;
                    ovl_d = cfg_overlap;
                    win_d = cfg_window;
                end
                if (start && len_ok) begin
                    state_d = S_RUN;
                    hist_d  = '0;
                    fill_d  = '0;
                    wcnt_d  = '0;
                    cnt_d   = '0;
                    wexp_d  = 1'b0;
`ifdef SEQ_DETECT_FIRST_POS_EN
                    fpos_d  = '0;
                    fvld_d  = 1'b0;
`endif
                end
            end

            S_RUN: begin
                if (din_valid) begin
                    hist_d = hist_shift;
                    fill_d = fill_inc;
                    wcnt_d = wcnt_inc;
                    if (hit) begin
                        match_d = 1'b1;
                        if (!(&cnt_q)) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        if (!ovl_q) begin
                            fill_d = '0;
                        end
`ifdef SEQ_DETECT_FIRST_POS_EN
                        if (!fvld_q) begin
                            fpos_d = wcnt_inc;
                            fvld_d = 1'b1;
                        end
`endif
                    end
                end
                // Window end wins over a simultaneous stop.
                if (din_valid && (win_q != '0) && (wcnt_inc == win_q)) begin
                    state_d = S_DONE;
                    wexp_d  = 1'b1;
                end else if (stop) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            win_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            wcnt_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            wexp_q  <= 1'b0;
`ifdef SEQ_DETECT_FIRST_POS_EN
            fpos_q  <= '0;
            fvld_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            win_q   <= win_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            wcnt_q  <= wcnt_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            wexp_q  <= wexp_d;
`ifdef SEQ_DETECT_FIRST_POS_EN
            fpos_q  <= fpos_d;
            fvld_q  <= fvld_d;
`endif
        end
    end

    assign cfg_ready   = (state_q == S_IDLE);
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign match       = match_q;
    assign match_cnt   = cnt_q;
    assign win_expired = wexp_q;
`ifdef SEQ_DETECT_FIRST_POS_EN
    assign first_pos   = fpos_q;
    assign first_vld   = fvld_q;
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_ctrl
//
// Bench for seq_detect_ctrl. Two instances share all inputs: one with the
// default counter width and one with a 2-bit counter for saturation. A
// behavioural model keeps the received bits in a queue and matches the tail
// against the pattern; a negedge process compares every output each cycle.
// Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_seq_detect_ctrl;

    localparam int PAT_W = 8;
    localparam int CNT_W = 8;
    localparam int WIN_W = 16;
    localparam int SAT_W = 2;
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_overlap = 1'b0;
    logic [WIN_W-1:0] cfg_window = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             din = 1'b0;
    logic             din_valid = 1'b0;

    logic             cfg_ready, busy, match, done, win_expired;
    logic [CNT_W-1:0] match_cnt;
    logic             cfg_ready_s, busy_s, match_s, done_s, win_expired_s;
    logic [SAT_W-1:0] match_cnt_s;
`ifdef SEQ_DETECT_FIRST_POS_EN
    logic [WIN_W-1:0] first_pos, first_pos_s;
    logic             first_vld, first_vld_s;
`endif

    always #5 clk = ~clk;

    seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) u_dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_window(cfg_window),
        .start(start), .stop(stop), .din(din), .din_valid(din_valid),
        .busy(busy), .match(match), .match_cnt(match_cnt), .done(done),
`ifdef SEQ_DETECT_FIRST_POS_EN
        .first_pos(first_pos), .first_vld(first_vld),
`endif
        .win_expired(win_expired)
    );

    seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(SAT_W), .WIN_W(WIN_W)) u_dut_sat (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_s),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_window(cfg_window),
        .start(start), .stop(stop), .din(din), .din_valid(din_valid),
        .busy(busy_s), .match(match_s), .match_cnt(match_cnt_s), .done(done_s),
`ifdef SEQ_DETECT_FIRST_POS_EN
        .first_pos(first_pos_s), .first_vld(first_vld_s),
`endif
        .win_expired(win_expired_s)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_phase: 0 idle, 1 running, 2 reporting done
    int               m_phase;
    logic [PAT_W-1:0] m_pat;
    int               m_len;
    bit               m_ovl;
    int               m_win;
    bit               m_match;
    bit               m_wexp;
    int               m_cnt;
    int               m_nvalid;
    int               m_fpos;
    bit               m_fvld;
    bit               m_bits[$];
    bit               model_on = 1'b0;

    function automatic int sat(input int v, input int w);
        int lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_pat = '0; m_len = 0; m_ovl = 0; m_win = 0;
        m_match = 0; m_wexp = 0; m_cnt = 0; m_nvalid = 0;
        m_fpos = 0; m_fvld = 0;
        m_bits.delete();
    endtask

    // Advances the model by one clock edge using the inputs held across it.
    task automatic model_step();
        bit hit;
        case (m_phase)
            0: begin
                bit go;
                m_match = 0;
                go = start && (m_len >= 1) && (m_len <= PAT_W);
                if (cfg_valid) begin
                    m_pat = cfg_pattern; m_len = int'(cfg_len);
                    m_ovl = cfg_overlap; m_win = int'(cfg_window);
                end
                if (go) begin
                    m_phase = 1; m_cnt = 0; m_nvalid = 0; m_wexp = 0;
                    m_fpos = 0; m_fvld = 0;
                    m_bits.delete();
                end
            end
            1: begin
                hit = 0;
                if (din_valid) begin
                    m_bits.push_back(din);
                    m_nvalid++;
                    if (m_bits.size() >= m_len) begin
                        hit = 1;
                        for (int i = 0; i < m_len; i++)
                            if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) hit = 0;
                    end
                    if (hit) begin
                        m_cnt++;
                        if (!m_fvld) begin m_fvld = 1; m_fpos = m_nvalid; end
                        if (!m_ovl) m_bits.delete();
                    end
                end
                m_match = hit;
                if (din_valid && m_win != 0 && m_nvalid == m_win) begin
                    m_phase = 2; m_wexp = 1;
                end else if (stop) begin
                    m_phase = 2;
                end
            end
            default: begin
                m_match = 0;
                m_phase = 0;
            end
        endcase
    endtask

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (model_on && reset) begin
            check("cfg_ready", cfg_ready, m_phase == 0);
            check("busy", busy, m_phase == 1);
            check("done", done, m_phase == 2);
            check("match", match, m_match);
            check("match_cnt", match_cnt, sat(m_cnt, CNT_W));
            check("win_expired", win_expired, m_wexp);
            check("sat_busy", busy_s, m_phase == 1);
            check("sat_match", match_s, m_match);
            check("sat_match_cnt", match_cnt_s, sat(m_cnt, SAT_W));
`ifdef SEQ_DETECT_FIRST_POS_EN
            check("first_vld", first_vld, m_fvld);
            check("first_pos", first_pos, m_fpos);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input bit cv, input bit st, input bit sp, input bit d, input bit dv);
        cfg_valid = cv; start = st; stop = sp; din = d; din_valid = dv;
        @(posedge clk);
        if (reset) model_step();
        #1;
    endtask

    task automatic configure(input logic [PAT_W-1:0] pat, input int len, input bit ovl, input int win);
        cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_overlap = ovl; cfg_window = WIN_W'(win);
        tick(1, 0, 0, 0, 0);
    endtask

    // Feeds n bits (first bit = vec[n-1]) one per cycle; mask bit k is set
    // when match is high right after the k-th (1-based) bit.
    task automatic stream(input logic [31:0] vec, input int n, output logic [63:0] mask);
        mask = '0;
        for (int k = 0; k < n; k++) begin
            tick(0, 0, 0, vec[n-1-k], 1);
            if (match) mask[k+1] = 1'b1;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && !cfg_ready; i++) tick(0, 0, 0, 0, 0);
        check("idle_timeout", cfg_ready, 1);
    endtask

    localparam logic [31:0] STREAM = 32'b1110_1010_1010;

    initial begin
        logic [63:0] mask;

        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        model_on = 1'b1;

        // Reset state
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_cnt", match_cnt, 0);
        check("rst_match", match, 0);
        check("rst_done", done, 0);
        check("rst_wexp", win_expired, 0);

        // start while unconfigured is ignored
        tick(0, 1, 0, 0, 0);
        check("len0_busy", busy, 0);

        // Overlapping matches
        configure(8'b1010, 4, 1, 0);
        tick(0, 1, 0, 0, 0);
        check("ovl_busy", busy, 1);
        stream(STREAM, 12, mask);
        check("ovl_mask", mask[31:0], 32'h1540);
        tick(0, 0, 1, 0, 0);
        check("ovl_done", done, 1);
        check("ovl_cnt", match_cnt, 4);
        check("ovl_sat_cnt", match_cnt_s, 3);
        check("ovl_wexp", win_expired, 0);
        tick(0, 0, 0, 0, 0);
        check("ovl_done_drop", done, 0);

        // Non-overlapping matches
        configure(8'b1010, 4, 0, 0);
        tick(0, 1, 0, 0, 0);
        stream(STREAM, 12, mask);
        check("novl_mask", mask[31:0], 32'h0440);
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 0);
        check("novl_cnt", match_cnt, 2);

        // Window of 5 ends before any match
        configure(8'b1010, 4, 1, 5);
        tick(0, 1, 0, 0, 0);
        stream(STREAM >> 7, 5, mask);
        check("win5_done", done, 1);
        check("win5_cnt", match_cnt, 0);
        check("win5_wexp", win_expired, 1);
        tick(0, 0, 0, 0, 0);
        check("win5_wexp_sticky", win_expired, 1);

        // Window of 6 counts the match on its final bit
        configure(8'b1010, 4, 1, 6);
        tick(0, 1, 0, 0, 0);
        stream(STREAM >> 6, 6, mask);
        check("win6_mask", mask[31:0], 32'h0040);
        check("win6_done", done, 1);
        check("win6_cnt", match_cnt, 1);
        check("win6_wexp", win_expired, 1);
        tick(0, 0, 0, 0, 0);

        // Gapped valid bits; config offered mid-run must be refused
        configure(8'b1010, 4, 1, 0);
        tick(0, 1, 0, 0, 0);
        cfg_pattern = 8'b0101;
        tick(1, 0, 0, 0, 0);
        check("run_cfg_ready", cfg_ready, 0);
        for (int k = 0; k < 4; k++) begin
            tick(0, 0, 0, (k % 2) == 0, 1);
            tick(0, 0, 0, (k % 2) != 0, 0);
        end
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 0);
        check("gap_cnt", match_cnt, 1);

        // Saturation on the narrow counter
        configure(8'b1, 1, 1, 0);
        tick(0, 1, 0, 0, 0);
        stream(32'h3f, 6, mask);
        tick(0, 0, 1, 0, 0);
        check("sat_cnt_wide", match_cnt, 6);
        check("sat_cnt_narrow", match_cnt_s, 3);
        tick(0, 0, 0, 0, 0);

        // Reset in the middle of a run
        configure(8'b1010, 4, 1, 0);
        tick(0, 1, 0, 0, 0);
        stream(STREAM >> 5, 7, mask);
        reset = 1'b0;
        #1;
        model_reset();
        check("midrst_busy", busy, 0);
        check("midrst_cnt", match_cnt, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        configure(8'b1010, 4, 1, 0);
        tick(0, 1, 0, 0, 0);
        stream(STREAM, 12, mask);
        tick(0, 0, 1, 0, 0);
        check("post_rst_cnt", match_cnt, 4);
        tick(0, 0, 0, 0, 0);

        // Randomized runs against the model
        for (int r = 0; r < 60; r++) begin
            logic [PAT_W-1:0] pat;
            int len, win, ncyc, idx, sel;
            bit ovl, d, dv, cv, st, sp;
            pat = PAT_W'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0) len = 0;
            else if (sel == 1) len = $urandom_range(PAT_W + 1, (1 << LEN_W) - 1);
            else if (sel < 6) len = $urandom_range(1, 4);
            else len = $urandom_range(1, PAT_W);
            ovl = $urandom_range(0, 1);
            win = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 24);
            configure(pat, len, ovl, win);
            tick(0, 1, 0, 0, 0);
            ncyc = $urandom_range(5, 40);
            idx = 0;
            for (int c = 0; c < ncyc; c++) begin
                dv = ($urandom_range(0, 3) != 0);
                if (len >= 1 && len <= PAT_W && $urandom_range(0, 3) != 0)
                    d = pat[len - 1 - (idx % len)];
                else
                    d = $urandom_range(0, 1);
                if (dv) idx++;
                cv = ($urandom_range(0, 7) == 0);
                if (cv) begin
                    cfg_pattern = PAT_W'($urandom);
                    cfg_len = LEN_W'($urandom_range(1, PAT_W));
                    cfg_overlap = $urandom_range(0, 1);
                    cfg_window = WIN_W'($urandom_range(0, 8));
                end
                st = (m_phase == 1) && ($urandom_range(0, 15) == 0);
                sp = ($urandom_range(0, 19) == 0);
                tick(cv, st, sp, d, dv);
            end
            tick(0, 0, (m_phase == 1), 0, 0);
            wait_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Programmable serial pattern-detection controller for the Moore sequence-detector datapath. It holds the detector configuration: pattern, length, overlap mode and observation window. It sequences a detection run (IDLE/RUN/DONE), qualifies input bits, and counts matches. Software or an upstream FSM loads the config over a valid/ready handshake, pulses start, and collects match_cnt when done fires.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
CNT_W, 8, match counter width (saturating)
WIN_W, 16, observation-window counter width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
cfg_valid  input  1  config offer
cfg_ready  output  1  config accepted when cfg_valid&cfg_ready; high only in IDLE
cfg_pattern  input  PAT_W  pattern; bit [len-1] is the first bit received
cfg_len  input  $clog2(PAT_W+1)  pattern length, legal 1..PAT_W
cfg_overlap  input  1  1 = overlapping matches allowed
cfg_window  input  WIN_W  valid bits per run; 0 = unlimited
start  input  1  begin run (IDLE only)
stop  input  1  abort run; behaves as window end
din  input  1  serial data bit
din_valid  input  1  din qualifier
busy  output  1  state==RUN
match  output  1  Moore match flag, registered
match_cnt  output  CNT_W  matches in current/last run
done  output  1  one-cycle pulse on RUN->DONE
win_expired  output  1  sticky: last run ended by window (not stop)

Behaviour:
- Reset (reset=0, async): state=IDLE; config regs 0 (cfg_len=0 = unconfigured); history, fill, window count, match_cnt, match, done, win_expired all 0.
- IDLE: cfg_ready=1; config is latched on handshake. start with latched len in 1..PAT_W -> RUN next edge; clears match_cnt, history, fill, window count and win_expired. start is ignored if len is 0 or >PAT_W. start has priority over a same-cycle config handshake; the config is still latched.
- RUN: cfg_ready=0; config frozen. Per din_valid=1 cycle: history <= {history[PAT_W-2:0],din}; fill <= min(fill+1,PAT_W); wcnt++. din_valid=0 cycles change nothing.
- Match condition on the updated history: fill>=len and history[len-1:0]==cfg_pattern[len-1:0]. The match register goes high on the edge after the completing bit's valid cycle (1-cycle latency) and stays high for exactly one cycle per match.
- On match: match_cnt++ (saturates at all-ones, no wrap). If cfg_overlap=0, fill is cleared to 0 so the next match needs len fresh bits.
- Exit from RUN -> DONE: wcnt reaches cfg_window (cfg_window!=0) on a valid bit, sets win_expired=1; or stop=1, win_expired stays 0. If both occur in the same cycle, the window takes precedence. A match completed on the final bit is still counted.
- DONE: single cycle, done=1, busy=0 -> IDLE. match_cnt holds until the next start.
- stop or start outside their legal states: ignored.
- Async reset mid-run: immediate return to IDLE; all counts lost.

Optional Feature:
SEQ_DETECT_FIRST_POS_EN: when defined, adds output first_pos [WIN_W-1:0] and flag first_vld. On the first match of a run, they capture the 1-based valid-bit index of the completing bit; both clear on start. When undefined, neither port exists and the logic is removed. All other behaviour is identical.

Test Plan:
- Overlap: len=4, pattern=4'b1010, overlap=1, window=0; din (valid every cycle) 1,1,1,0,1,0,1,0,1,0,1,0, then stop -> match pulses after bits 6,8,10,12; match_cnt=4; done one cycle; win_expired=0.
- Non-overlap: same stream, overlap=0 -> matches after bits 6 and 10 only; match_cnt=2.
- Window: same stream, overlap=1, window=5 -> done after 5th valid bit; match_cnt=0; win_expired=1. With window=6 -> match_cnt=1, win_expired=1.
- Gaps/handshake: din_valid low every other cycle with stream 1,0,1,0 -> one match, no extra shifts. cfg_valid during RUN -> cfg_ready=0 and config unchanged. start with len=0 -> stays IDLE.
- Saturation: CNT_W=2, pattern 1'b1 len=1, 6 ones -> match_cnt=3, no wrap.
- Reset mid-run: reset=0 after bit 7 of overlap test -> busy=0, match_cnt=0 immediately; new start after release behaves as fresh run.
